ram_arbiter: RTL and testbench

//  Shares the single 128K x 8 SRAM between three requesters: CPU (after address decode), video fetch and SPI/MCU bridge.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arb_pick.sv | 29 ++
 rtl/ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: requester ids, FSM states, address width.
package ram_arbiter_pkg;

  localparam int RAM_ADDR_WIDTH = 17;

  typedef enum logic [1:0] {
    REQ_CPU,
    REQ_VIDEO,
    REQ_SPI
  } ram_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_STROBE,
    ARB_HOLD
  } ram_arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select: CPU first unless skipped, then VIDEO/SPI
// round-robin starting at rr_ptr.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  ram_req_t   rr_ptr,
  input  logic       cpu_skip,
  output logic [2:0] win
);

  logic others;
  logic vid_first;

  assign others    = req[1] | req[2];
  assign vid_first = (rr_ptr == REQ_VIDEO) || !req[2];

  // A skip only matters when someone else is actually waiting.
  always_comb begin
    win = 3'b000;
    if (req[0] && !(cpu_skip && others))
      win = 3'b001;
    else if (req[1] && vid_first)
      win = 3'b010;
    else if (req[2])
      win = 3'b100;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Three-way SRAM arbiter with SETUP/STROBE/HOLD pin sequencing.
// Optional CPU burst limiting is enabled with RAM_ARB_FAIRNESS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic                      sys_clock_i,
  input  logic                      sys_reset_n_i,
  input  logic [2:0]                req_i,
  input  logic [2:0]                wr_i,
  input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [RAM_ADDR_WIDTH-1:0] video_addr_i,
  input  logic [RAM_ADDR_WIDTH-1:0] spi_addr_i,
  input  logic [7:0]                cpu_data_i,
  input  logic [7:0]                spi_data_i,
  input  logic                      cpu_rom_i,
  input  logic [7:0]                ram_data_i,
  output logic [2:0]                grant_o,
  output logic [2:0]                ack_o,
  output logic [7:0]                rd_data_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]                ram_data_o,
  output logic                      ram_data_oe_o,
  output logic                      ram_we_n_o,
  output logic                      ram_oe_n_o
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
    $error("ACCESS_CYCLES must be 1..15");
  end
  if (MAX_CPU_BURST < 1) begin : g_bad_burst
    $error("MAX_CPU_BURST must be >= 1");
  end

  ram_arb_state_t            state, state_n;
  ram_req_t                  rr_ptr, rr_n;
  logic [3:0]                cnt, cnt_n;
  logic [2:0]                win, grant_n, ack_n;
  logic [7:0]                rd_n, wdata_n;
  logic [RAM_ADDR_WIDTH-1:0] addr_n;
  logic                      doe_n, we_n_n, oe_n_n;
  logic                      write, write_n, rom, rom_n;
  logic                      cpu_skip;
  logic                      unused_wr;

  // Video never writes.
  assign unused_wr = wr_i[1];

  ram_arb_pick u_pick (
    .req      (req_i),
    .rr_ptr   (rr_ptr),
    .cpu_skip (cpu_skip),
    .win      (win)
  );

`ifdef RAM_ARB_FAIRNESS_EN
  localparam int BW = $clog2(MAX_CPU_BURST + 1);
  logic [BW-1:0] burst, burst_n;

  assign cpu_skip = (burst == BW'(MAX_CPU_BURST));

  // Any IDLE outcome other than a CPU grant restarts the run.
  always_comb begin
    burst_n = burst;
    if (state == ARB_IDLE) begin
      if (win == 3'b001) begin
        if (burst != BW'(MAX_CPU_BURST))
          burst_n = burst + 1'b1;
      end else begin
        burst_n = '0;
      end
    end
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) burst <= '0;
    else                burst <= burst_n;
  end
`else
  assign cpu_skip = 1'b0;
`endif

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    grant_n = grant_o;
    ack_n   = 3'b000;
    rd_n    = rd_data_o;
    addr_n  = ram_addr_o;
    wdata_n = ram_data_o;
    doe_n   = ram_data_oe_o;
    we_n_n  = 1'b1;
    oe_n_n  = 1'b1;
    write_n = write;
    rom_n   = rom;
    unique case (state)
      ARB_IDLE: begin
        if (|req_i) begin
          state_n = ARB_SETUP;
          grant_n = win;
          unique case (1'b1)
            win[1]: begin
              addr_n  = video_addr_i;
              write_n = 1'b0;
              rom_n   = 1'b0;
              rr_n    = REQ_SPI;
            end
            win[2]: begin
              addr_n  = spi_addr_i;
              wdata_n = spi_data_i;
              write_n = wr_i[2];
              rom_n   = 1'b0;
              rr_n    = REQ_VIDEO;
            end
            default: begin
              addr_n  = cpu_addr_i;
              wdata_n = cpu_data_i;
              write_n = wr_i[0];
              rom_n   = cpu_rom_i;
            end
          endcase
          doe_n = write_n;
        end
      end
      ARB_SETUP: begin
        state_n = ARB_STROBE;
        cnt_n   = 4'(ACCESS_CYCLES);
        // ROM-mapped writes run the full cycle with the strobe held off.
        we_n_n  = !(write && !rom);
        oe_n_n  = write;
      end
      ARB_STROBE: begin
        if (cnt == 4'd1) begin
          state_n = ARB_HOLD;
          ack_n   = grant_o;
          if (!write) rd_n = ram_data_i;
        end else begin
          cnt_n  = cnt - 1'b1;
          we_n_n = ram_we_n_o;
          oe_n_n = ram_oe_n_o;
        end
      end
      ARB_HOLD: begin
        state_n = ARB_IDLE;
        grant_n = 3'b000;
        doe_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clock_i) begin
    if (!sys_reset_n_i) begin
      state         <= ARB_IDLE;
      rr_ptr        <= REQ_VIDEO;
      cnt           <= '0;
      grant_o       <= '0;
      ack_o         <= '0;
      rd_data_o     <= '0;
      ram_addr_o    <= '0;
      ram_data_o    <= '0;
      ram_data_oe_o <= 1'b0;
      ram_we_n_o    <= 1'b1;
      ram_oe_n_o    <= 1'b1;
      write         <= 1'b0;
      rom           <= 1'b0;
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_n;
      cnt           <= cnt_n;
      grant_o       <= grant_n;
      ack_o         <= ack_n;
      rd_data_o     <= rd_n;
      ram_addr_o    <= addr_n;
      ram_data_o    <= wdata_n;
      ram_data_oe_o <= doe_n;
      ram_we_n_o    <= we_n_n;
      ram_oe_n_o    <= oe_n_n;
      write         <= write_n;
      rom           <= rom_n;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM pin model, arbitration reference model,
// directed and random slots, plus ACCESS_CYCLES=1/15 instances.
module tb_ram_arbiter;

  localparam int AC   = 2;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, wr;
  logic [16:0] cpu_addr, video_addr, spi_addr;
  logic [7:0]  cpu_data, spi_data;
  logic        cpu_rom;
  logic [7:0]  ram_rdata;

  logic [2:0]  grant, ack;
  logic [7:0]  rd_data, ram_data;
  logic [16:0] ram_addr;
  logic        data_oe, we_n, oe_n;

  logic [2:0]  g1, a1, g15, a15;
  logic [7:0]  rd1, dt1, rd15, dt15;
  logic [16:0] ad1, ad15;
  logic        doe1, we1, oe1, doe15, we15, oe15;

  logic [7:0] sram    [0:131071];
  logic [7:0] exp_mem [0:131071];

  int total = 0;
  int bad   = 0;
  bit vid_next;
  int burst;

  always #5 clk = ~clk;

  assign ram_rdata = sram[ram_addr];

  // SRAM latches on the trailing edge of its write strobe.
  always @(posedge we_n)
    if (data_oe === 1'b1) sram[ram_addr] = ram_data;

  ram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .sys_clock_i(clk), .sys_reset_n_i(rst_n), .req_i(req), .wr_i(wr),
    .cpu_addr_i(cpu_addr), .video_addr_i(video_addr), .spi_addr_i(spi_addr),
    .cpu_data_i(cpu_data), .spi_data_i(spi_data), .cpu_rom_i(cpu_rom),
    .ram_data_i(ram_rdata), .grant_o(grant), .ack_o(ack), .rd_data_o(rd_data),
    .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_data_oe_o(data_oe),
    .ram_we_n_o(we_n), .ram_oe_n_o(oe_n));

  ram_arbiter #(.ACCESS_CYCLES(1)) u1 (
    .sys_clock_i(clk), .sys_reset_n_i(rst_n), .req_i(req), .wr_i(wr),
    .cpu_addr_i(cpu_addr), .video_addr_i(video_addr), .spi_addr_i(spi_addr),
    .cpu_data_i(cpu_data), .spi_data_i(spi_data), .cpu_rom_i(cpu_rom),
    .ram_data_i(8'h3C), .grant_o(g1), .ack_o(a1), .rd_data_o(rd1),
    .ram_addr_o(ad1), .ram_data_o(dt1), .ram_data_oe_o(doe1),
    .ram_we_n_o(we1), .ram_oe_n_o(oe1));

  ram_arbiter #(.ACCESS_CYCLES(15)) u15 (
    .sys_clock_i(clk), .sys_reset_n_i(rst_n), .req_i(req), .wr_i(wr),
    .cpu_addr_i(cpu_addr), .video_addr_i(video_addr), .spi_addr_i(spi_addr),
    .cpu_data_i(cpu_data), .spi_data_i(spi_data), .cpu_rom_i(cpu_rom),
    .ram_data_i(8'h3C), .grant_o(g15), .ack_o(a15), .rd_data_o(rd15),
    .ram_addr_o(ad15), .ram_data_o(dt15), .ram_data_oe_o(doe15),
    .ram_we_n_o(we15), .ram_oe_n_o(oe15));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Priority list built from the rules: CPU, then the round-robin pair;
  // when the CPU has had its burst and others wait, CPU moves to the back.
  function automatic logic [2:0] model_pick(input logic [2:0] r);
    int order[$];
    int first, second;
    bit skip;
    first  = vid_next ? 1 : 2;
    second = 3 - first;
    skip   = 1'b0;
`ifdef RAM_ARB_FAIRNESS_EN
    skip = (burst >= MAXB) && (r[1] || r[2]);
`endif
    if (!skip) order.push_back(0);
    order.push_back(first);
    order.push_back(second);
    if (skip) order.push_back(0);
    foreach (order[i])
      if (r[order[i]]) return 3'(1 << order[i]);
    return 3'b000;
  endfunction

  task automatic model_commit(input logic [2:0] g);
    if (g == 3'b001) burst = (burst < MAXB) ? burst + 1 : burst;
    else burst = 0;
    if (g == 3'b010) vid_next = 1'b0;
    if (g == 3'b100) vid_next = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the IDLE negedge after HOLD.
  task automatic run_slot(input string tag);
    logic [2:0]  eg;
    logic [16:0] ea;
    logic [7:0]  ed;
    logic        ew, ewe;
    int w, k, we_cnt, oe_cnt, doe_bad;
    eg = model_pick(req);
    ea = cpu_addr; ed = cpu_data; ew = wr[0]; ewe = wr[0] && !cpu_rom;
    if (eg == 3'b010) begin ea = video_addr; ed = 8'h00; ew = 0; ewe = 0; end
    if (eg == 3'b100) begin ea = spi_addr; ed = spi_data; ew = wr[2]; ewe = wr[2]; end
    w = 0;
    do begin @(negedge clk); w++; end while (grant === 3'b000 && w < 20);
    check({tag, "_wait"}, w, 1);
    check({tag, "_grant"}, grant, eg);
    check({tag, "_addr"}, ram_addr, ea);
    check({tag, "_setup_doe"}, data_oe, ew);
    check({tag, "_setup_strb"}, {we_n, oe_n}, 2'b11);
    if (ew) check({tag, "_wdata"}, ram_data, ed);
    we_cnt = 0; oe_cnt = 0; doe_bad = 0;
    for (k = 2; k < 40; k++) begin
      @(negedge clk);
      if (ack !== 3'b000) break;
      if (we_n === 1'b0) we_cnt++;
      if (oe_n === 1'b0) oe_cnt++;
      if (data_oe !== ew) doe_bad++;
    end
    check({tag, "_ack"}, ack, eg);
    check({tag, "_latency"}, k, 2 + AC);
    check({tag, "_we_width"}, we_cnt, ewe ? AC : 0);
    check({tag, "_oe_width"}, oe_cnt, ew ? 0 : AC);
    check({tag, "_doe_strobe"}, doe_bad, 0);
    check({tag, "_hold"}, {data_oe, we_n, oe_n}, {ew, 2'b11});
    if (!ew) check({tag, "_rdata"}, rd_data, exp_mem[ea]);
    model_commit(eg);
    if (ewe) exp_mem[ea] = ed;
    check({tag, "_mem"}, sram[ea], exp_mem[ea]);
    @(negedge clk);
    check({tag, "_idle"}, {grant, ack, data_oe}, 7'b0);
  endtask

  task automatic idle_cycle();
    req = 3'b000;
    @(negedge clk);
    burst = 0;
  endtask

  initial begin
    int s1, s15, d1, d15, n1, n15;
    bit done1, done15;
    logic [7:0] b;
    for (int i = 0; i < 131072; i++) begin
      b = 8'($urandom);
      sram[i] = b;
      exp_mem[i] = b;
    end
    sram[17'h1234] = 8'hA5;
    exp_mem[17'h1234] = 8'hA5;
    rst_n = 1'b0; req = 0; wr = 0; cpu_rom = 0;
    cpu_addr = 0; video_addr = 0; spi_addr = 0; cpu_data = 0; spi_data = 0;
    vid_next = 1'b1; burst = 0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {grant, ack, data_oe, we_n, oe_n}, 9'b0_0000_0011);
    check("rst_data", {rd_data, ram_data}, 16'h0);
    check("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // CPU read of a known byte
    req = 3'b001; wr = 3'b000; cpu_addr = 17'h1234;
    run_slot("cpu_rd");
    idle_cycle();

    // CPU write, then ROM-mapped write that must be dropped
    req = 3'b001; wr = 3'b001; cpu_addr = 17'h0400; cpu_data = 8'h5A;
    run_slot("cpu_wr");
    idle_cycle();
    check("wr_byte", sram[17'h0400], 8'h5A);
    req = 3'b001; cpu_addr = 17'h0F000; cpu_data = ~exp_mem[17'h0F000];
    cpu_rom = 1'b1;
    run_slot("rom_wr");
    idle_cycle();
    cpu_rom = 1'b0;

    // Randomized single slots
    for (int i = 0; i < 12; i++) begin
      req = 3'($urandom_range(1, 7));
      wr = 3'($urandom);
      cpu_rom = 1'($urandom);
      cpu_addr = 17'($urandom);
      video_addr = 17'($urandom);
      spi_addr = 17'($urandom);
      cpu_data = 8'($urandom);
      spi_data = 8'($urandom);
      run_slot("rand");
      idle_cycle();
    end
    cpu_rom = 1'b0;

    // All three held: strict CPU priority or bursted fairness
    req = 3'b111; wr = 3'b000;
    for (int i = 0; i < 11; i++) run_slot("all3");
    idle_cycle();

    // VIDEO and SPI only; video write bit must never strobe
    req = 3'b110; wr = 3'b110;
    for (int i = 0; i < 6; i++) begin
      spi_data = 8'($urandom);
      run_slot("vid_spi");
    end
    idle_cycle();

    // Reset during the strobe of a write aborts it
    req = 3'b001; wr = 3'b001; cpu_addr = 17'($urandom);
    cpu_data = exp_mem[cpu_addr];
    n1 = 0;
    do begin @(negedge clk); n1++; end while (we_n !== 1'b0 && n1 < 10);
    check("abort_reach_strobe", we_n, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_pins", {grant, ack, data_oe, we_n, oe_n}, 9'b0_0000_0011);
    req = 3'b000;
    @(negedge clk);
    check("abort_noack", ack, 3'b000);
    vid_next = 1'b1; burst = 0;
    rst_n = 1'b1;
    req = 3'b110; wr = 3'b000;
    video_addr = 17'($urandom); spi_addr = 17'($urandom);
    run_slot("post_rst");
    idle_cycle();

    // Strobe width and latency at ACCESS_CYCLES=1 and 15
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req = 3'b001; wr = 3'b000; cpu_addr = 17'($urandom);
    s1 = 0; s15 = 0; d1 = 0; d15 = 0; n1 = 0; n15 = 0;
    done1 = 0; done15 = 0;
    for (int c = 1; c < 40 && !(done1 && done15); c++) begin
      @(negedge clk);
      if (!done1) begin
        if (g1 !== 3'b000 && s1 == 0) s1 = c;
        if (oe1 === 1'b0) n1++;
        if (a1 !== 3'b000) begin d1 = c; done1 = 1; check("ac1_ack", a1, 3'b001); end
      end
      if (!done15) begin
        if (g15 !== 3'b000 && s15 == 0) s15 = c;
        if (oe15 === 1'b0) n15++;
        if (a15 !== 3'b000) begin d15 = c; done15 = 1; check("ac15_ack", a15, 3'b001); end
      end
    end
    req = 3'b000;
    check("ac1_setup", s1, 1);
    check("ac1_latency", d1, 3);
    check("ac1_width", n1, 1);
    check("ac15_setup", s15, 1);
    check("ac15_latency", d15, 17);
    check("ac15_width", n15, 15);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
